// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM controller: FSM state, latency range check, word-mask merge.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Upper bound on row width accepted by maskMerge; rows must be strictly narrower.
    localparam int MERGE_MAX_WIDTH = 2048;
    localparam int MERGE_IDX_W     = $clog2(MERGE_MAX_WIDTH);

    function automatic bit legalReadLatency(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

    // Word i of the result comes from newVal when wordMask[i] is set, else from oldVal.
    function automatic logic [MERGE_MAX_WIDTH-1:0] maskMerge(
        input logic [MERGE_MAX_WIDTH-1:0] oldVal,
        input logic [MERGE_MAX_WIDTH-1:0] newVal,
        input logic [MERGE_MAX_WIDTH-1:0] wordMask,
        input int                         wordSize
    );
        logic [MERGE_MAX_WIDTH-1:0] result;
        logic [MERGE_IDX_W-1:0]     bitIdx;
        logic [MERGE_IDX_W-1:0]     wordIdx;
        result = oldVal;
        for (int b = 0; b < MERGE_MAX_WIDTH; b++) begin
            bitIdx          = MERGE_IDX_W'(b);
            wordIdx         = MERGE_IDX_W'(b / wordSize);
            result[bitIdx]  = wordMask[wordIdx] ? newVal[bitIdx] : oldVal[bitIdx];
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bundle between a pipeline (master) and the SRAM controller (slave).
// Reads and writes use independent valid/ready; read responses carry no backpressure.
interface sram_ctrl_if #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64
);
    localparam int NUM_WORDS = WIDTH / WORD_SIZE;

    logic                    init_req;
    logic                    busy;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [LOG_NUM_ROWS-1:0] rd_addr;
    logic                    rd_resp_valid;
    logic [WIDTH-1:0]        rd_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [LOG_NUM_ROWS-1:0] wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [NUM_WORDS-1:0]    wr_mask;

    modport master (
        output init_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_mask,
        input  busy, rd_ready, rd_resp_valid, rd_data, wr_ready
    );

    modport slave (
        input  init_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_mask,
        output busy, rd_ready, rd_resp_valid, rd_data, wr_ready
    );

endinterface

// File: rtl/sram_ctrl_array.sv
// Storage array: one synchronous read port (read-first), one write port with per-word mask.
// Read data registered on the read-enable edge; no reset so it maps onto SRAM macros.
module sram_ctrl_array
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64
) (
    input  logic                          clk,
    input  logic                          rdEn,
    input  logic [LOG_NUM_ROWS-1:0]       rdAddr,
    output logic [WIDTH-1:0]              rdData,
    input  logic                          wrEn,
    input  logic [LOG_NUM_ROWS-1:0]       wrAddr,
    input  logic [WIDTH-1:0]              wrData,
    input  logic [WIDTH/WORD_SIZE-1:0]    wrMask
);
    localparam int NUM_ROWS = 2 ** LOG_NUM_ROWS;

    logic [WIDTH-1:0]           mem [NUM_ROWS];
    logic [MERGE_MAX_WIDTH-1:0] mergeFull;
    logic                       unusedMergeBits;

    always_comb begin
        mergeFull = maskMerge(MERGE_MAX_WIDTH'(mem[wrAddr]), MERGE_MAX_WIDTH'(wrData),
                              MERGE_MAX_WIDTH'(wrMask), WORD_SIZE);
    end

    assign unusedMergeBits = ^mergeFull[MERGE_MAX_WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= mergeFull[WIDTH-1:0];
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: init sweep FSM, read/write handshakes, collision bypass, 1/2-cycle read pipeline.
// Read response READ_LATENCY edges after acceptance; ready is low only while the init sweep runs.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int               WIDTH        = 512,
    parameter int               LOG_NUM_ROWS = 9,
    parameter int               WORD_SIZE    = 64,
    parameter int               READ_LATENCY = 1,
    parameter int               BYPASS       = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE   = '1
) (
    input logic        clk,
    input logic        reset,
    sram_ctrl_if.slave bus
);
    localparam int NUM_WORDS = WIDTH / WORD_SIZE;

    if (!legalReadLatency(READ_LATENCY)) begin : gBadLatency
        $error("sram_ctrl: READ_LATENCY must be 1 or 2");
    end
    if ((WIDTH % WORD_SIZE) != 0 || WIDTH >= MERGE_MAX_WIDTH) begin : gBadWidth
        $error("sram_ctrl: WIDTH must be a multiple of WORD_SIZE and below MERGE_MAX_WIDTH");
    end

    state_t                  state;
    logic [LOG_NUM_ROWS-1:0] initPtr;
    logic                    busyQ;
    logic                    readyQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            initPtr <= '0;
            busyQ   <= 1'b1;
            readyQ  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    initPtr <= initPtr + 1'b1;
                    if (initPtr == '1) begin
                        state  <= RUN;
                        busyQ  <= 1'b0;
                        readyQ <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.init_req) begin
                        state   <= INIT;
                        initPtr <= '0;
                        busyQ   <= 1'b1;
                        readyQ  <= 1'b0;
                    end
                end
                default: begin
                    state   <= INIT;
                    initPtr <= '0;
                    busyQ   <= 1'b1;
                    readyQ  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busyQ;
    assign bus.rd_ready = readyQ;
    assign bus.wr_ready = readyQ;

    logic rdAcc;
    logic wrAcc;
    assign rdAcc = bus.rd_valid & readyQ;
    assign wrAcc = bus.wr_valid & readyQ;

    // The sweep owns the write port; no requests are accepted while it runs.
    logic                    arrWrEn;
    logic [LOG_NUM_ROWS-1:0] arrWrAddr;
    logic [WIDTH-1:0]        arrWrData;
    logic [NUM_WORDS-1:0]    arrWrMask;

    always_comb begin
        arrWrEn   = wrAcc;
        arrWrAddr = bus.wr_addr;
        arrWrData = bus.wr_data;
        arrWrMask = bus.wr_mask;
        if (state == INIT) begin
            arrWrEn   = 1'b1;
            arrWrAddr = initPtr;
            arrWrData = INIT_VALUE;
            arrWrMask = '1;
        end
    end

    logic [WIDTH-1:0] arrRdData;

    sram_ctrl_array #(
        .WIDTH        (WIDTH),
        .LOG_NUM_ROWS (LOG_NUM_ROWS),
        .WORD_SIZE    (WORD_SIZE)
    ) uArray (
        .clk    (clk),
        .rdEn   (rdAcc),
        .rdAddr (bus.rd_addr),
        .rdData (arrRdData),
        .wrEn   (arrWrEn),
        .wrAddr (arrWrAddr),
        .wrData (arrWrData),
        .wrMask (arrWrMask)
    );

    // Array reads old data on a collision; the bypass mask selects which words to replace.
    logic                 arrVld;
    logic [NUM_WORDS-1:0] bypMask;
    logic [WIDTH-1:0]     bypData;
    logic                 collide;

    assign collide = (BYPASS != 0) && wrAcc && (bus.rd_addr == bus.wr_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrVld  <= 1'b0;
            bypMask <= '0;
        end else begin
            arrVld <= rdAcc;
            if (rdAcc) begin
                bypMask <= collide ? bus.wr_mask : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdAcc) begin
            bypData <= bus.wr_data;
        end
    end

    logic [MERGE_MAX_WIDTH-1:0] rdMergeFull;
    logic                       unusedRdMergeBits;

    always_comb begin
        rdMergeFull = maskMerge(MERGE_MAX_WIDTH'(arrRdData), MERGE_MAX_WIDTH'(bypData),
                                MERGE_MAX_WIDTH'(bypMask), WORD_SIZE);
    end

    assign unusedRdMergeBits = ^rdMergeFull[MERGE_MAX_WIDTH-1:WIDTH];

    logic             respVld1;
    logic [WIDTH-1:0] respDat1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            respVld1 <= 1'b0;
            respDat1 <= '0;
        end else begin
            respVld1 <= arrVld;
            if (arrVld) begin
                respDat1 <= rdMergeFull[WIDTH-1:0];
            end
        end
    end

    if (READ_LATENCY == 2) begin : gLat2
        logic             respVld2;
        logic [WIDTH-1:0] respDat2;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                respVld2 <= 1'b0;
                respDat2 <= '0;
            end else begin
                respVld2 <= respVld1;
                if (respVld1) begin
                    respDat2 <= respDat1;
                end
            end
        end

        assign bus.rd_resp_valid = respVld2;
        assign bus.rd_data       = respDat2;
    end else begin : gLat1
        assign bus.rd_resp_valid = respVld1;
        assign bus.rd_data       = respDat1;
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench driving three controller variants (bypass/lat1, read-first/lat1, bypass/lat2) with shared stimulus.
// Expected responses come from a row-array model and are queued per variant for a negedge monitor.
module tb_sram_ctrl;
    localparam int W  = 512;
    localparam int LR = 9;
    localparam int WS = 64;
    localparam int NW = W / WS;
    localparam int NR = 1 << LR;

    typedef logic [W-1:0] row_t;
    typedef struct {
        row_t data;
        int   due;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          initReq = 1'b0;
    logic          rdValid = 1'b0;
    logic          wrValid = 1'b0;
    logic [LR-1:0] rdAddr  = '0;
    logic [LR-1:0] wrAddr  = '0;
    row_t          wrData  = '0;
    logic [NW-1:0] wrMask  = '0;

    sram_ctrl_if #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS)) bus0 ();
    sram_ctrl_if #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS)) bus1 ();
    sram_ctrl_if #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS)) bus2 ();

    assign bus0.init_req = initReq;  assign bus1.init_req = initReq;  assign bus2.init_req = initReq;
    assign bus0.rd_valid = rdValid;  assign bus1.rd_valid = rdValid;  assign bus2.rd_valid = rdValid;
    assign bus0.rd_addr  = rdAddr;   assign bus1.rd_addr  = rdAddr;   assign bus2.rd_addr  = rdAddr;
    assign bus0.wr_valid = wrValid;  assign bus1.wr_valid = wrValid;  assign bus2.wr_valid = wrValid;
    assign bus0.wr_addr  = wrAddr;   assign bus1.wr_addr  = wrAddr;   assign bus2.wr_addr  = wrAddr;
    assign bus0.wr_data  = wrData;   assign bus1.wr_data  = wrData;   assign bus2.wr_data  = wrData;
    assign bus0.wr_mask  = wrMask;   assign bus1.wr_mask  = wrMask;   assign bus2.wr_mask  = wrMask;

    sram_ctrl #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS), .READ_LATENCY(1), .BYPASS(1))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    sram_ctrl #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS), .READ_LATENCY(1), .BYPASS(0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    sram_ctrl #(.WIDTH(W), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS), .READ_LATENCY(2), .BYPASS(1))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic respVld[3];
    logic busyS[3];
    logic rdRdyS[3];
    logic wrRdyS[3];
    row_t respDat[3];

    assign respVld[0] = bus0.rd_resp_valid;  assign respDat[0] = bus0.rd_data;
    assign respVld[1] = bus1.rd_resp_valid;  assign respDat[1] = bus1.rd_data;
    assign respVld[2] = bus2.rd_resp_valid;  assign respDat[2] = bus2.rd_data;
    assign busyS[0]   = bus0.busy;           assign rdRdyS[0]  = bus0.rd_ready;  assign wrRdyS[0] = bus0.wr_ready;
    assign busyS[1]   = bus1.busy;           assign rdRdyS[1]  = bus1.rd_ready;  assign wrRdyS[1] = bus1.wr_ready;
    assign busyS[2]   = bus2.busy;           assign rdRdyS[2]  = bus2.rd_ready;  assign wrRdyS[2] = bus2.wr_ready;

    // Reference model: plain row array plus a count of sweep cycles still to run.
    row_t  mem[NR];
    int    busyLeft;
    resp_t expQ[3][$];
    row_t  lastDat[3];
    int    latOf[3] = '{1, 1, 2};
    bit    bypOf[3] = '{1'b1, 1'b0, 1'b1};
    int    checks   = 0;
    int    failures = 0;
    resp_t e;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic row_t applyWrite(input row_t old, input row_t d, input logic [NW-1:0] m);
        row_t r = old;
        for (int w = 0; w < NW; w++) begin
            if (m[w]) r[w*WS +: WS] = d[w*WS +: WS];
        end
        return r;
    endfunction

    // After reset the sweep will leave every row all-ones before anything is accepted.
    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            expQ[i].delete();
            lastDat[i] = '0;
        end
        busyLeft = NR;
        for (int r = 0; r < NR; r++) mem[r] = '1;
    endtask

    // Called just after a posedge with inputs set; models the next edge and returns just after it.
    task automatic tick();
        row_t oldRow;
        row_t newRow;
        bit   col;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy%0d", i),    busyS[i],  busyLeft > 0);
            check($sformatf("rd_ready%0d", i), rdRdyS[i], busyLeft == 0);
            check($sformatf("wr_ready%0d", i), wrRdyS[i], busyLeft == 0);
        end
        if (busyLeft > 0) begin
            busyLeft--;
        end else begin
            if (rdValid) begin
                oldRow = mem[rdAddr];
                newRow = applyWrite(oldRow, wrData, wrMask);
                col    = wrValid && (wrAddr == rdAddr);
                for (int i = 0; i < 3; i++)
                    expQ[i].push_back('{data: (col && bypOf[i]) ? newRow : oldRow, due: cyc + 1 + latOf[i]});
            end
            if (wrValid) mem[wrAddr] = applyWrite(mem[wrAddr], wrData, wrMask);
            if (initReq) begin
                busyLeft = NR;
                for (int r = 0; r < NR; r++) mem[r] = '1;
            end
        end
        @(posedge clk);
        #1;
        rdValid = 1'b0;
        wrValid = 1'b0;
        initReq = 1'b0;
    endtask

    task automatic rd(input int a);
        rdValid = 1'b1;
        rdAddr  = LR'(a);
    endtask

    task automatic wr(input int a, input row_t d, input logic [NW-1:0] m);
        wrValid = 1'b1;
        wrAddr  = LR'(a);
        wrData  = d;
        wrMask  = m;
    endtask

    task automatic countBusy(input string name);
        int n = 0;
        while (busyS[0] && n < NR + 20) begin
            tick();
            n++;
        end
        check(name, n, NR);
    endtask

    task automatic drain();
        int n = 0;
        while ((busyLeft > 0 || expQ[0].size() > 0 || expQ[1].size() > 0 || expQ[2].size() > 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_bound", n < 2000, 1'b1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                if (respVld[i]) begin
                    if (expQ[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp%0d actual=valid required=idle cyc=%0d", i, cyc);
                    end else begin
                        e = expQ[i].pop_front();
                        check($sformatf("rd_data%0d", i), respDat[i], e.data);
                        check($sformatf("resp_cycle%0d", i), cyc, e.due);
                    end
                    lastDat[i] = respDat[i];
                end else begin
                    check($sformatf("rd_data_hold%0d", i), respDat[i], lastDat[i]);
                    if (expQ[i].size() > 0 && expQ[i][0].due <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missing_resp%0d actual=idle required=valid due=%0d cyc=%0d", i, expQ[i][0].due, cyc);
                        void'(expQ[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t d;
        #1 reset = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy%0d", i),  busyS[i],   1'b1);
            check($sformatf("reset_rdy%0d", i),   rdRdyS[i],  1'b0);
            check($sformatf("reset_wrdy%0d", i),  wrRdyS[i],  1'b0);
            check($sformatf("reset_vld%0d", i),   respVld[i], 1'b0);
            check($sformatf("reset_data%0d", i),  respDat[i], '0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        modelReset();
        countBusy("initial_sweep_cycles");

        rd(0);   tick();
        rd(255); tick();
        rd(511); tick();
        drain();

        d = '0;
        for (int w = 0; w < NW; w++) d[w*WS +: WS] = WS'(w);
        wr(5, d, 8'b0000_0101); tick();
        rd(5); tick();
        wr(7, '0, 8'hFF); rd(7); tick();
        rd(7); tick();
        drain();

        for (int a = 1; a <= 3; a++) begin
            wr(a, W'(a), 8'hFF); tick();
        end
        for (int a = 1; a <= 3; a++) begin
            rd(a); tick();
        end
        drain();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) != 0) rd(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom();
                wr(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 15), d, NW'($urandom()));
            end
            if ($urandom_range(0, 999) == 0) initReq = 1'b1;
            tick();
        end
        drain();

        wr(3, '0, 8'hFF); tick();
        rd(3); initReq = 1'b1; tick();
        while (busyS[0] && busyLeft > 0) begin
            rd($urandom_range(0, 15));
            wr($urandom_range(0, 15), '0, 8'hFF);
            tick();
        end
        rd(3); tick();
        drain();

        initReq = 1'b1; tick();
        repeat (100) tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("midsweep_reset_busy%0d", i), busyS[i], 1'b1);
        modelReset();
        @(posedge clk);
        #1 reset = 1'b1;
        modelReset();
        countBusy("restart_sweep_cycles");

        rd(9); tick();
        tick();
        check("inflight_pre_vld0", respVld[0], 1'b1);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("inflight_drop_vld%0d", i),  respVld[i], 1'b0);
            check($sformatf("inflight_drop_data%0d", i), respDat[i], '0);
        end
        modelReset();
        @(posedge clk);
        #1 reset = 1'b1;
        modelReset();
        countBusy("post_drop_sweep_cycles");
        rd(9); tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
